// File: rtl/flash_cmd_pkg.sv
// Shared encodings for the flash command sequencer: command codes, byte-select
// codes and the last step index of each command's byte table.
package flash_cmd_pkg;

    localparam logic [1:0] CMD_PROGRAM      = 2'd0;
    localparam logic [1:0] CMD_SECTOR_ERASE = 2'd1;
    localparam logic [1:0] CMD_CHIP_ERASE   = 2'd2;
    localparam logic [1:0] CMD_RAW_WRITE    = 2'd3;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_DATA = 3'd1;
    localparam logic [2:0] SEL_AA   = 3'd2;
    localparam logic [2:0] SEL_55   = 3'd3;
    localparam logic [2:0] SEL_B0   = 3'd4;
    localparam logic [2:0] SEL_C0   = 3'd5;
    localparam logic [2:0] SEL_D0   = 3'd6;
    localparam logic [2:0] SEL_E0   = 3'd7;

    localparam logic [2:0] LAST_PROGRAM      = 3'd3;
    localparam logic [2:0] LAST_SECTOR_ERASE = 3'd5;
    localparam logic [2:0] LAST_CHIP_ERASE   = 3'd5;
    localparam logic [2:0] LAST_RAW_WRITE    = 3'd0;

    function automatic logic [2:0] last_step(input logic [1:0] c);
        case (c)
            CMD_PROGRAM:      return LAST_PROGRAM;
            CMD_SECTOR_ERASE: return LAST_SECTOR_ERASE;
            CMD_CHIP_ERASE:   return LAST_CHIP_ERASE;
            default:          return LAST_RAW_WRITE;
        endcase
    endfunction

endpackage

// File: rtl/flash_cmd_rom.sv
// Fixed byte tables: maps (command, step) to the byte-select code for that step.
module flash_cmd_rom
    import flash_cmd_pkg::*;
(
    input  logic [1:0] cmd_i,
    input  logic [2:0] step_i,
    output logic [2:0] sel_o
);

    always_comb begin
        sel_o = SEL_NONE;
        case (cmd_i)
            CMD_PROGRAM: begin
                case (step_i)
                    3'd0:    sel_o = SEL_AA;
                    3'd1:    sel_o = SEL_55;
                    3'd2:    sel_o = SEL_B0;
                    3'd3:    sel_o = SEL_DATA;
                    default: sel_o = SEL_NONE;
                endcase
            end
            CMD_SECTOR_ERASE, CMD_CHIP_ERASE: begin
                case (step_i)
                    3'd0, 3'd3: sel_o = SEL_AA;
                    3'd1, 3'd4: sel_o = SEL_55;
                    3'd2:       sel_o = SEL_C0;
                    3'd5:       sel_o = (cmd_i == CMD_SECTOR_ERASE) ? SEL_D0 : SEL_E0;
                    default:    sel_o = SEL_NONE;
                endcase
            end
            default: sel_o = (step_i == 3'd0) ? SEL_DATA : SEL_NONE;
        endcase
    end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Issues the unlock-and-command byte sequence for a flash operation, one byte
// per transmitter handshake; all outputs are registered off SCL.
module flash_cmd_sequencer
    import flash_cmd_pkg::*;
(
    input  logic       SCL,
    input  logic       rstN,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic       byteDone,
    input  logic       nack,
    output logic       selData,
    output logic       selAA,
    output logic       sel55,
    output logic       selB0,
    output logic       selC0,
    output logic       selD0,
    output logic       selE0,
    output logic       byteReq,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEND   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_FINISH = 3'd3;
    localparam logic [2:0] ST_ABORT  = 3'd4;

    logic [2:0] state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic [2:0] step_q, step_d;
    logic [2:0] sel_q, sel_d;
    logic       byte_req_q, busy_q, done_q, err_q;
    logic [2:0] rom_sel;

    flash_cmd_rom u_rom (
        .cmd_i  (cmd_q),
        .step_i (step_q),
        .sel_o  (rom_sel)
    );

    // busy_q still reads high for one cycle after FINISH/ABORT, which keeps a
    // start in that cycle from being accepted.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    cmd_d   = cmd;
                    step_d  = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (nack) begin
                    state_d = ST_ABORT;
                end else if (byteDone) begin
                    if (step_q < last_step(cmd_q)) begin
                        step_d  = step_q + 3'd1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d = SEL_NONE;
        case (state_q)
            ST_SEND: sel_d = rom_sel;
            ST_WAIT: sel_d = sel_q;
            default: sel_d = SEL_NONE;
        endcase
    end

    always_ff @(posedge SCL or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_PROGRAM;
            step_q     <= 3'd0;
            sel_q      <= SEL_NONE;
            byte_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            step_q     <= step_d;
            sel_q      <= sel_d;
            byte_req_q <= (state_q == ST_SEND);
            busy_q     <= (state_q != ST_IDLE);
            done_q     <= (state_q == ST_FINISH);
            err_q      <= (state_q == ST_ABORT);
        end
    end

    assign selData = (sel_q == SEL_DATA);
    assign selAA   = (sel_q == SEL_AA);
    assign sel55   = (sel_q == SEL_55);
    assign selB0   = (sel_q == SEL_B0);
    assign selC0   = (sel_q == SEL_C0);
    assign selD0   = (sel_q == SEL_D0);
    assign selE0   = (sel_q == SEL_E0);
    assign byteReq = byte_req_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Randomized bench for flash_cmd_sequencer against a byte-list reference model.
module tb_flash_cmd_sequencer;

    logic       SCL = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       byteDone = 1'b0;
    logic       nack = 1'b0;
    logic selData, selAA, sel55, selB0, selC0, selD0, selE0;
    logic byteReq, busy, done, err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    flash_cmd_sequencer dut (
        .SCL(SCL), .rstN(rstN), .start(start), .cmd(cmd),
        .byteDone(byteDone), .nack(nack),
        .selData(selData), .selAA(selAA), .sel55(sel55), .selB0(selB0),
        .selC0(selC0), .selD0(selD0), .selE0(selE0),
        .byteReq(byteReq), .busy(busy), .done(done), .err(err)
    );

    always #5 SCL = ~SCL;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed byte: 'h100 = DATA, 0 = none, 'h1FF = more than one select high.
    function automatic logic [31:0] obs();
        if ($countones({selData, selAA, sel55, selB0, selC0, selD0, selE0}) > 1) return 'h1FF;
        if (selData) return 'h100;
        if (selAA) return 'hAA;
        if (sel55) return 'h55;
        if (selB0) return 'hB0;
        if (selC0) return 'hC0;
        if (selD0) return 'hD0;
        if (selE0) return 'hE0;
        return 0;
    endfunction

    function automatic int seq_len(input int c);
        case (c)
            0: return 4;
            1: return 6;
            2: return 6;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] seq_byte(input int c, input int i);
        int prog[4]  = '{'hAA, 'h55, 'hB0, 'h100};
        int sect[6]  = '{'hAA, 'h55, 'hC0, 'hAA, 'h55, 'hD0};
        int chip[6]  = '{'hAA, 'h55, 'hC0, 'hAA, 'h55, 'hE0};
        case (c)
            0: return prog[i];
            1: return sect[i];
            2: return chip[i];
            default: return 'h100;
        endcase
    endfunction

    always @(negedge SCL)
        chk("onehot", 32'($countones({selData, selAA, sel55, selB0, selC0, selD0, selE0}) <= 1), 1);

    task automatic tick();
        @(posedge SCL);
        #1;
        cyc++;
    endtask

    // One command from start to done/err; nack_at < 0 means no NACK, rst_at >= 0
    // pulls reset right after that byte's request.
    task automatic run(input int c, input int nack_at, input bit both, input int dmin,
                       input int dmax, input bit poke, input int rst_at);
        string t;
        int d;
        int sumd = 0;
        int c0;
        start = 1'b1;
        cmd = 2'(c);
        tick();
        start = 1'b0;
        c0 = cyc;
        for (int i = 0; i < seq_len(c); i++) begin
            tick();
            t = $sformatf("c%0d b%0d", c, i);
            chk({t, " req"}, 32'(byteReq), 1);
            chk({t, " sel"}, obs(), seq_byte(c, i));
            chk({t, " busy"}, 32'(busy), 1);
            if (i == rst_at) begin
                #2 rstN = 1'b0;
                #1;
                chk({t, " rst sel"}, obs(), 0);
                chk({t, " rst out"}, 32'({byteReq, busy, done, err}), 0);
                @(posedge SCL);
                #2 rstN = 1'b1;
                return;
            end
            d = $urandom_range(dmax, dmin);
            if (poke && d == 0) d = 1;
            sumd += d;
            for (int k = 0; k < d; k++) begin
                if (poke && k == 0) begin
                    start = 1'b1;
                    cmd = 2'd0;
                end
                tick();
                start = 1'b0;
                chk({t, " hold req"}, 32'(byteReq), 0);
                chk({t, " hold sel"}, obs(), seq_byte(c, i));
            end
            byteDone = (i != nack_at) || both;
            nack = (i == nack_at);
            tick();
            byteDone = 1'b0;
            nack = 1'b0;
            if (i == nack_at) begin
                tick();
                chk({t, " abort err"}, 32'(err), 1);
                chk({t, " abort done"}, 32'(done), 0);
                chk({t, " abort sel"}, obs(), 0);
                chk({t, " abort busy"}, 32'(busy), 1);
                tick();
                chk({t, " abort busy off"}, 32'({busy, err, byteReq}), 0);
                return;
            end
        end
        tick();
        t = $sformatf("c%0d end", c);
        chk({t, " done"}, 32'(done), 1);
        chk({t, " err"}, 32'(err), 0);
        chk({t, " sel"}, obs(), 0);
        chk({t, " busy"}, 32'(busy), 1);
        chk({t, " cycles"}, 32'(cyc - c0), 32'(2 * seq_len(c) + 1 + sumd));
        tick();
        chk({t, " idle"}, 32'({busy, done, err, byteReq}), 0);
    endtask

    initial begin
        tick();
        chk("reset sel", obs(), 0);
        chk("reset out", 32'({byteReq, busy, done, err}), 0);
        rstN = 1'b1;
        tick();

        run(0, -1, 1'b0, 1, 1, 1'b0, -1);   // PROGRAM, fixed pacing
        run(2, -1, 1'b0, 0, 3, 1'b0, -1);   // CHIP_ERASE
        run(1, 2, 1'b0, 0, 2, 1'b0, -1);    // SECTOR_ERASE, NACK on C0
        run(3, -1, 1'b0, 1, 3, 1'b1, -1);   // RAW_WRITE with start poked while busy
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no stray start", 32'({busy, byteReq}), 0);
        end
        run(0, -1, 1'b0, 0, 2, 1'b0, 2);    // reset during PROGRAM step 2
        tick();
        chk("post rst idle", 32'({busy, byteReq, done, err}), 0);
        run(2, -1, 1'b0, 0, 0, 1'b0, -1);   // CHIP_ERASE after reset
        run(0, 0, 1'b1, 0, 1, 1'b0, -1);    // byteDone+nack on first byte

        byteDone = 1'b1;
        nack = 1'b1;
        tick();
        byteDone = 1'b0;
        nack = 1'b0;
        tick();
        chk("idle handshake", 32'({busy, byteReq, done, err}), 0);

        for (int n = 0; n < 20; n++) begin
            int c;
            int na;
            c = int'($urandom_range(3, 0));
            na = ($urandom_range(3, 0) == 0) ? int'($urandom_range(seq_len(c) - 1, 0)) : -1;
            run(c, na, 1'($urandom_range(1, 0)), 0, 3, 1'($urandom_range(1, 0)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_cmd_sequencer.md
# flash_cmd_sequencer

Command sequencer that drives the byte-select lines of the write-data mux in the I2C flash memory model. On a one-cycle start request it issues the unlock-and-command byte sequence for a flash operation, one byte per handshake. It sits directly upstream of the write-data mux, which captures the selected byte on the falling SCL edge, and it paces itself on the byte-complete/NACK feedback from the I2C byte transmitter.

## Interface
Parameters:
- none; sequence tables are fixed constants.

Ports:
- SCL  input  1  sole clock; all state updates on rising edge.
- rstN  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request, sampled only in IDLE.
- cmd  input  2  operation: 0 PROGRAM, 1 SECTOR_ERASE, 2 CHIP_ERASE, 3 RAW_WRITE; sampled with start.
- byteDone  input  1  transmitter reports the current byte was sent and ACKed.
- nack  input  1  transmitter reports the current byte was NACKed.
- selData, selAA, sel55, selB0, selC0, selD0, selE0  output  1 each  one-hot (or all-zero) byte select to the write mux.
- byteReq  output  1  one-cycle pulse: a new select is valid; transmitter loads after the next falling edge.
- busy  output  1  high from the cycle after an accepted start until the sequence ends.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on abort due to NACK.

## Operation
Sequences, with bytes listed in order:
- PROGRAM: AA, 55, B0, DATA.
- SECTOR_ERASE: AA, 55, C0, AA, 55, D0.
- CHIP_ERASE: AA, 55, C0, AA, 55, E0.
- RAW_WRITE: DATA.

State machine:
- IDLE: start=1 latches cmd and clears step to 0 → SEND.
- SEND: asserts the select for table[cmd][step], pulses byteReq → WAIT.
- WAIT: holds the select.
  - nack → ABORT.
  - Else byteDone with step < last: step+1 → SEND.
  - Else byteDone with step = last → FINISH.
- FINISH: selects low, done=1 → IDLE.
- ABORT: selects low, err=1 → IDLE.

Rules:
- step is a 3-bit counter, range 0..5; last index is 3/5/5/0 per cmd.
- At most one select is high in any cycle.
- start is ignored while busy; it is neither queued nor fatal.
- nack and byteDone together: nack wins and the sequence aborts.
- byteDone or nack while in IDLE, SEND, FINISH or ABORT: ignored.

## Timing
- Reset values: all selects 0, byteReq 0, busy 0, done 0, err 0, state IDLE, step 0. Reset is asynchronous; rstN low mid-sequence drops every output to 0 immediately, with no done or err.
- start at rising edge N:
  - Select for step 0 and byteReq high after edge N+1.
  - busy high after edge N+1.
  - The mux captures the byte at the falling edge between N+1 and N+2.
- byteDone sampled high at edge M (state WAIT): the next select and byteReq appear after edge M+1.
- Last byteDone at edge M: selects 0 and done=1 after edge M+1; busy=0 after edge M+2.
- nack at edge M: err=1 and selects 0 after edge M+1; busy=0 after edge M+2.
- Minimum per-byte spacing is 2 cycles. Byte count × 2 + 1 cycles from start to done, assuming immediate byteDone:
  - PROGRAM: 9.
  - SECTOR_ERASE and CHIP_ERASE: 13.
  - RAW_WRITE: 3.
- A new start is accepted from the cycle in which busy is low.

## Structure
- Shared package, `flash_cmd_pkg`, holds:
  - cmd encodings: CMD_PROGRAM, CMD_SECTOR_ERASE, CMD_CHIP_ERASE, CMD_RAW_WRITE.
  - byte-select encodings: SEL_NONE, SEL_DATA, SEL_AA, SEL_55, SEL_B0, SEL_C0, SEL_D0, SEL_E0.
  - last-step constants per cmd.
- One sub-module is natural: `flash_cmd_rom`.
  - Combinational lookup of (cmd, step) → select code.
  - A decoder in the top converts the code to the seven one-hot outputs.

## Test plan
- PROGRAM, byteDone 2 cycles after each byteReq → selects AA, 55, B0, DATA, one per byte; 4 byteReq pulses; done once; err never.
- CHIP_ERASE → AA, 55, C0, AA, 55, E0; step reaches 5; done once; D0 never selected.
- SECTOR_ERASE with nack on the 3rd byte (C0) → err pulse after the next edge; selects 0; no done; busy low 2 cycles after nack.
- start with cmd=0 while busy (mid-RAW_WRITE) → ignored; RAW_WRITE completes with a single DATA byte; PROGRAM never starts.
- rstN low during PROGRAM step 2 → all outputs 0 asynchronously; after release, a new CHIP_ERASE starts cleanly at AA.
- byteDone and nack high in the same cycle on byte 1 → abort with err, no advance to 55; checker asserts selects are one-hot-or-zero on every cycle throughout.
